// File: rtl/superio_pkg.sv
// Shared types and defaults for the super-I/O register bank bus interface.
package superio_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} rd_state_t;
  localparam int SUPERIO_DEFAULT_WAIT = 4;
endpackage

// File: rtl/signal_sync.sv
// Two-flop synchronizer with a selectable reset value; reused for IOR# and IOW#.
module signal_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);
  logic r_meta, r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/isa_reg_reader.sv
// ISA IOR# responder: latches the addressed register onto the data bus,
// stretches the cycle with IOCHRDY and strobes the per-register read pulse.
module isa_reg_reader
  import superio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = SUPERIO_DEFAULT_WAIT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ior_n,
  input  logic                           cs_n,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           dout_oe,
  output logic                           iochrdy,
  output logic [NUM_REGS-1:0]            rd_pulse,
  output logic                           busy
);
  localparam int NSLOTS = 2 ** ADDR_WIDTH;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  rd_state_t                         r_state;
  logic [CNT_W-1:0]                  r_cnt;
  logic [DATA_WIDTH-1:0]             r_dout;
  logic                              r_oe, r_rdy, r_busy, r_ior_d;
  logic [NUM_REGS-1:0]               r_pulse;
  logic                              w_ior_s, w_addr_ok, w_start;
  logic [NSLOTS-1:0]                 w_onehot;
  logic [NSLOTS-1:0][DATA_WIDTH-1:0] w_regs;

  // Reset value 0 (strobe asserted) so a read already in progress at reset release is ignored.
  signal_sync #(.RST_VAL(1'b0)) u_ior_sync (
    .clk    (clk),
    .rst_n  (reset),
    .i_async(ior_n),
    .o_sync (w_ior_s)
  );

  // Unimplemented offsets read as zero; they can never start a cycle anyway.
  for (genvar i = 0; i < NSLOTS; i++) begin : g_regs
    if (i < NUM_REGS) begin : g_impl
      assign w_regs[i] = reg_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign w_regs[i] = '0;
    end
  end

  assign w_addr_ok = {1'b0, addr} < (ADDR_WIDTH + 1)'(NUM_REGS);
  assign w_start   = !w_ior_s && r_ior_d && !cs_n && w_addr_ok;
  assign w_onehot  = NSLOTS'(1) << addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_oe    <= 1'b0;
      r_rdy   <= 1'b1;
      r_pulse <= '0;
      r_busy  <= 1'b0;
      r_ior_d <= 1'b0;
    end else begin
      r_ior_d <= w_ior_s;
      r_pulse <= '0;
      case (r_state)
        IDLE: if (w_start) begin
          r_dout  <= w_regs[addr];
          r_oe    <= 1'b1;
          r_pulse <= w_onehot[NUM_REGS-1:0];
          r_busy  <= 1'b1;
          if (WAIT_CYCLES > 0) begin
            r_rdy   <= 1'b0;
            r_cnt   <= CNT_INIT;
            r_state <= WAIT;
          end else begin
            r_state <= HOLD;
          end
        end
        // A host that drops IOR# early wins over the wait countdown.
        WAIT: if (w_ior_s) begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
        end else if (r_cnt == '0) begin
          r_state <= HOLD;
          r_rdy   <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        HOLD: if (w_ior_s) begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout     = r_dout;
  assign dout_oe  = r_oe;
  assign iochrdy  = r_rdy;
  assign rd_pulse = r_pulse;
  assign busy     = r_busy;
endmodule

// File: tb/tb_isa_reg_reader.sv
// Scoreboard bench: DUT A (8 regs, 4 waits) and DUT B (6 regs, no waits) share one ISA bus.
module tb_isa_reg_reader;
  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ior_n, cs_n;
  logic [2:0]  addr;
  logic [7:0]  regs [8];
  logic [63:0] reg_data;
  logic [47:0] reg_data_b;

  logic [7:0] a_dout, b_dout;
  logic       a_oe, a_rdy, a_busy, b_oe, b_rdy, b_busy;
  logic [7:0] a_pulse;
  logic [5:0] b_pulse;

  exp_t qa[$], qb[$];
  int   n_chk = 0, n_fail = 0;
  bit   exp_abort = 0;

  always #5 clk = ~clk;

  always_comb begin
    reg_data = '0;
    for (int i = 0; i < 8; i++) reg_data[i*8 +: 8] = regs[i];
  end
  assign reg_data_b = reg_data[47:0];

  isa_reg_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8), .WAIT_CYCLES(4)) dut_a (
    .clk(clk), .reset(rst_n), .ior_n(ior_n), .cs_n(cs_n), .addr(addr), .reg_data(reg_data),
    .dout(a_dout), .dout_oe(a_oe), .iochrdy(a_rdy), .rd_pulse(a_pulse), .busy(a_busy));

  isa_reg_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(6), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_n), .ior_n(ior_n), .cs_n(cs_n), .addr(addr), .reg_data(reg_data_b),
    .dout(b_dout), .dout_oe(b_oe), .iochrdy(b_rdy), .rd_pulse(b_pulse), .busy(b_busy));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitors: pop the scoreboard on every read pulse, measure IOCHRDY low runs.
  logic [7:0] prev_a_pulse = '0;
  logic [5:0] prev_b_pulse = '0;
  int         a_low = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (prev_a_pulse != 0) chk("a_pulse_one_cycle", 64'(a_pulse), 64'(0));
      if (a_pulse != 0) begin
        if (qa.size() == 0) chk("a_unexpected_pulse", 64'(a_pulse), 64'(0));
        else begin
          e = qa.pop_front();
          chk("a_rd_pulse", 64'(a_pulse), 64'(8'd1 << e.addr));
          chk("a_dout", 64'(a_dout), 64'(e.data));
          chk("a_oe_at_capture", 64'(a_oe), 64'(1));
        end
      end
      if (!a_rdy) a_low++;
      else if (a_low > 0) begin
        if (exp_abort) chk("a_abort_rdy_oe", 64'({a_low < 4, a_oe}), 64'(2'b10));
        else begin
          chk("a_wait_len", 64'(a_low), 64'(4));
          chk("a_oe_after_wait", 64'(a_oe), 64'(1));
        end
        a_low = 0;
      end
      prev_a_pulse = a_pulse;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (prev_b_pulse != 0) chk("b_pulse_one_cycle", 64'(b_pulse), 64'(0));
      if (b_pulse != 0) begin
        if (qb.size() == 0) chk("b_unexpected_pulse", 64'(b_pulse), 64'(0));
        else begin
          e = qb.pop_front();
          chk("b_rd_pulse", 64'(b_pulse), 64'(6'd1 << e.addr));
          chk("b_dout", 64'(b_dout), 64'(e.data));
          chk("b_oe_at_capture", 64'(b_oe), 64'(1));
        end
      end
      if (b_busy) chk("b_iochrdy_high", 64'(b_rdy), 64'(1));
      prev_b_pulse = b_pulse;
    end
  end

  function automatic exp_t mk(input logic [2:0] a);
    exp_t e;
    e.addr = a;
    e.data = regs[a];
    return e;
  endfunction

  // One host read; the model decides which cards answer from cs_n and register count.
  task automatic rd(input logic [2:0] a, input logic cs, input bit ab, input int extra);
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    addr = a; cs_n = cs;
    step(1);
    if (!cs) begin
      qa.push_back(mk(a));
      if (a < 6) qb.push_back(mk(a));
    end
    exp_abort = ab;
    ior_n = 1'b0;
    if (ab) step(3);
    else begin
      step(4);
      @(negedge clk);
      chk("a_busy_mid", 64'(a_busy), 64'(!cs));
      chk("a_oe_mid", 64'(a_oe), 64'(!cs));
      chk("b_busy_mid", 64'(b_busy), 64'(!cs && a < 6));
      chk("b_oe_mid", 64'(b_oe), 64'(!cs && a < 6));
      if (cs) chk("a_rdy_noresp", 64'(a_rdy), 64'(1));
      step(3 + extra);
    end
    ior_n = 1'b1;
    step(4);
    cs_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ior_n = 1'b1; cs_n = 1'b1; addr = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    step(3);
    @(negedge clk);
    chk("rst_a_dout", 64'(a_dout), 64'(0));
    chk("rst_a_oe", 64'(a_oe), 64'(0));
    chk("rst_a_rdy", 64'(a_rdy), 64'(1));
    chk("rst_a_pulse", 64'(a_pulse), 64'(0));
    chk("rst_a_busy", 64'(a_busy), 64'(0));
    chk("rst_b_busy_oe", 64'({b_busy, b_oe, b_rdy}), 64'(3'b001));
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(3);

    // Basic read of register 2 with explicit latency and data-hold checks.
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    regs[2] = 8'hA5; addr = 3'd2; cs_n = 1'b0;
    step(1);
    qa.push_back(mk(3'd2)); qb.push_back(mk(3'd2));
    exp_abort = 0;
    ior_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("basic_oe_before_e3", 64'(a_oe), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("basic_dout", 64'(a_dout), 64'(8'hA5));
    chk("basic_oe", 64'(a_oe), 64'(1));
    chk("basic_rdy_low", 64'(a_rdy), 64'(0));
    chk("basic_pulse", 64'(a_pulse), 64'(8'b0000_0100));
    chk("basic_b_dout", 64'(b_dout), 64'(8'hA5));
    repeat (5) @(posedge clk);
    #2 regs[2] = 8'h3C;
    @(negedge clk);
    chk("hold_dout", 64'(a_dout), 64'(8'hA5));
    chk("hold_b_dout", 64'(b_dout), 64'(8'hA5));
    @(posedge clk); #2 ior_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("release_n", 64'(a_oe), 64'(1));
    @(posedge clk); @(negedge clk);
    chk("release_n1", 64'(a_oe), 64'(1));
    @(posedge clk); @(negedge clk);
    chk("release_n2_a", 64'(a_oe), 64'(0));
    chk("release_n2_b", 64'(b_oe), 64'(0));
    step(2);
    cs_n = 1'b1;

    // No response and zero-wait reads, then an abort.
    rd(3'd4, 1'b1, 0, 0);
    rd(3'd7, 1'b0, 0, 1);
    rd(3'd0, 1'b0, 0, 0);
    rd(3'd3, 1'b0, 1, 0);

    // Reset during WAIT, released with IOR# still low.
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    addr = 3'd5; cs_n = 1'b0;
    step(1);
    qa.push_back(mk(3'd5)); qb.push_back(mk(3'd5));
    exp_abort = 1;
    ior_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_rdy", 64'(a_rdy), 64'(1));
    chk("midrst_a_oe", 64'(a_oe), 64'(0));
    chk("midrst_a_busy", 64'(a_busy), 64'(0));
    chk("midrst_a_dout", 64'(a_dout), 64'(0));
    chk("midrst_b_oe", 64'(b_oe), 64'(0));
    step(2);
    rst_n = 1'b1;
    step(6);
    @(negedge clk);
    chk("postrst_a_busy", 64'(a_busy), 64'(0));
    chk("postrst_a_oe", 64'(a_oe), 64'(0));
    chk("postrst_b_busy", 64'(b_busy), 64'(0));
    @(posedge clk); #2 ior_n = 1'b1;
    step(4);
    cs_n = 1'b1;

    for (int k = 0; k < 30; k++)
      rd(3'($urandom_range(7)), ($urandom_range(4) == 0), ($urandom_range(5) == 0),
         int'($urandom_range(3)));

    step(5);
    chk("qa_drained", 64'(qa.size()), 64'(0));
    chk("qb_drained", 64'(qb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/isa_reg_reader.md
# isa_reg_reader

ISA I/O-read responder for the super-I/O register bank: the read-side counterpart to the dual-path register write logic. On a chip-selected IOR# strobe it selects one register's current value from a flat bus, latches it onto the data-bus driver and inserts IOCHRDY wait states. It also emits a one-cycle per-register read strobe, which read-to-clear and pop-on-read registers use. It sits between the card's address decoder and bus transceiver and the register instances.

## Interface
- `DATA_WIDTH`, 8, register and data-bus width
- `ADDR_WIDTH`, 3, register offset width
- `NUM_REGS`, 8, implemented registers; must satisfy NUM_REGS ≤ 2^ADDR_WIDTH
- `WAIT_CYCLES`, 4, clk cycles IOCHRDY is held low; 0 means no wait states
- `clk`  in  1  system clock; one clock domain
- `reset`  in  1  asynchronous, active-low reset
- `ior_n`  in  1  ISA IOR# strobe, asynchronous to `clk`, active low
- `cs_n`  in  1  chip select from the address decoder, active low; stable while IOR# is low
- `addr`  in  ADDR_WIDTH  register offset; stable while IOR# is low
- `reg_data`  in  NUM_REGS*DATA_WIDTH  flat register values; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `dout`  out  DATA_WIDTH  latched read data
- `dout_oe`  out  1  enable for the data-bus transceiver, active high
- `iochrdy`  out  1  0 inserts a wait state; the open-drain driver is external
- `rd_pulse`  out  NUM_REGS  one-hot read strobe, high for one cycle
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- **Synchronizer:** two flops bring `ior_n` into the clock domain as `ior_s`. A third flop holds `ior_d`, the previous value of `ior_s`. All three flops reset to 0 (strobe asserted).
- **Start condition:** `ior_s`=0, `ior_d`=1 and `cs_n`=0 while in IDLE, and `addr` < NUM_REGS.
- **FSM states:** IDLE, WAIT, HOLD.
- **IDLE → WAIT or HOLD, on the start condition, at one edge:**
  - `dout` ← `reg_data[addr]`
  - `dout_oe` ← 1
  - `rd_pulse[addr]` ← 1 (all other bits 0)
  - If WAIT_CYCLES > 0: `iochrdy` ← 0, counter ← WAIT_CYCLES-1, next state WAIT.
  - If WAIT_CYCLES = 0: next state HOLD.
- **WAIT:**
  - Counter == 0 → HOLD, `iochrdy` ← 1. Otherwise decrement the counter.
  - `ior_s`=1 (bus violation) → IDLE; `iochrdy` ← 1 and `dout_oe` ← 0.
- **HOLD:** `ior_s`=1 → IDLE, `dout_oe` ← 0.
- **Registered outputs:** all outputs are registered. `rd_pulse` clears on the edge after it is set.
- **No response:** if `cs_n`=1 or `addr` ≥ NUM_REGS, the block stays in IDLE, does not drive the bus and does not pulse.
- **Re-trigger:** a new read needs `ior_s` to return high and then fall again. A strobe held low never re-triggers.
- **Data hold:** `dout` is held from capture until the next capture. Changes on `reg_data` after capture are ignored.
- **Counter width:** $clog2(WAIT_CYCLES+1), minimum 1 bit.

## Timing
- **Reset values:** `dout`=0, `dout_oe`=0, `iochrdy`=1, `rd_pulse`=0, `busy`=0, state IDLE, counter 0.
- **Reset assertion:** takes effect immediately, at any point including mid-WAIT.
- **Start latency:** `ior_n` falls before edge 1; `dout`, `dout_oe`, `rd_pulse` and `iochrdy`=0 are valid after edge 3.
- **Wait length:** `iochrdy` is low for exactly WAIT_CYCLES clk cycles, then returns to 1 for as long as IOR# stays asserted.
- **Release latency:** `ior_n` rises before edge n; `dout_oe` falls after edge n+2.
- **Clock requirement:** clk ≥ 8× the ISA bus clock, so that IOCHRDY falls before the bus samples it.
- **Reset released with IOR# still low:** no response, because the synchronizer resets to the asserted value.

## Structure
- **Shared package `superio_pkg`:**
  - state typedef: `rd_state_t` {IDLE, WAIT, HOLD}
  - constant `SUPERIO_DEFAULT_WAIT` = 4, used as the WAIT_CYCLES default
- **Sub-module `signal_sync`:** a 2-flop synchronizer with a parameterized reset value. It is instantiated once here and is reusable for IOW#.
- **Read mux:** indexed part-select on `reg_data`; no separate module.

## Test plan
- **Reset values:** assert `reset` → all outputs hold the reset values above; `busy`=0.
- **Basic read:** `reg_data[2]`=0xA5, `addr`=2, `cs_n`=0, `ior_n` low → after edge 3 `dout`=0xA5, `dout_oe`=1, `rd_pulse`=8'b0000_0100 for one cycle, `iochrdy`=0 for 4 cycles then 1. Raise `ior_n` → `dout_oe`=0 three edges later.
- **No response:** `cs_n`=1, or NUM_REGS=6 with `addr`=7 → `dout_oe`, `rd_pulse` and `iochrdy` never change; `busy`=0 throughout.
- **Abort:** release `ior_n` 2 cycles into WAIT → IDLE, with `iochrdy`=1 and `dout_oe`=0 on the same edge; no second `rd_pulse`.
- **Reset mid-read, held data:**
  - assert `reset` during WAIT → outputs reset immediately; release `reset` with `ior_n` still low → no response.
  - in a separate read, change `reg_data[2]` to 0x3C during HOLD → `dout` stays 0xA5.
- **Zero wait states:** WAIT_CYCLES=0, read `addr`=0 → `iochrdy` stays 1 throughout, the FSM goes directly to HOLD, and `dout` is valid after edge 3.
